mul_int_iter_ctrl: RTL and testbench

Iterative sequencer for the 13-row full-width Wallace compressor (`wtree_13bits_full`) in the mul_int unit. It performs an unsigned OP_WIDTH×OP_WIDTH multiply as a series of compressor passes. Each pass feeds 11 partial-product rows plus the 2 carry-save accumulator rows from the previous pass. After the last pass it resolves the carry-save pair into the final product. It sits between a valid/ready operand source and a valid/ready result sink, and owns the tree's inputs exclusively.

---
 rtl/mul_int_pkg.sv | 20 ++
 rtl/mul_int_pp_rowgen.sv | 33 +++
 rtl/wtree_13bits_full.sv | 41 ++++
 rtl/mul_int_iter_ctrl.sv | 137 +++++++++++++
 tb/tb_mul_int_iter_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_int_pkg.sv
// Shared types and constants for the iterative mul_int datapath.
// Holds the controller state encoding and pass-count arithmetic.
package mul_int_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINAL,
    DONE
  } state_e;

  localparam int TREE_ROWS        = 13;
  localparam int PP_ROWS_PER_PASS = 11;

  function automatic int num_passes(input int op_width);
    return (op_width + PP_ROWS_PER_PASS - 1) / PP_ROWS_PER_PASS;
  endfunction

endpackage

// File: rtl/mul_int_pp_rowgen.sv
// Partial-product row generator: the 11 shifted-multiplicand rows of one pass.
// Rows whose multiplier bit lies beyond OP_WIDTH are forced to zero.
module mul_int_pp_rowgen
  import mul_int_pkg::*;
#(
  parameter int OP_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int PASS_W     = 2
) (
  input  logic [OP_WIDTH-1:0]                             a,
  input  logic [OP_WIDTH-1:0]                             b,
  input  logic [PASS_W-1:0]                               pass_cnt,
  output logic [PP_ROWS_PER_PASS-1:0][DATA_WIDTH-1:0]     rows
);

  localparam int IDX_W = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] a_ext;
  assign a_ext = DATA_WIDTH'(a);

  always_comb begin
    int idx;
    idx  = 0;
    rows = '0;
    for (int r = 0; r < PP_ROWS_PER_PASS; r++) begin
      idx = PP_ROWS_PER_PASS * int'(pass_cnt) + r;
      if (idx < OP_WIDTH) begin
        if (b[idx[IDX_W-1:0]]) rows[r] = a_ext << idx;
      end
    end
  end

endmodule

// File: rtl/wtree_13bits_full.sv
// 13-row full-width carry-save compressor with one register stage.
// sout + (cout << 1) equals the sum of all rows plus cin, mod 2^DATA_WIDTH.
module wtree_13bits_full #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clock,
  input  logic [13*DATA_WIDTH-1:0] src,
  input  logic [9:0]              cin,
  output logic [DATA_WIDTH-1:0]   sout,
  output logic [DATA_WIDTH-1:0]   cout
);

  logic [DATA_WIDTH-1:0] s_c, c_c, x, y, z;

  // Chain of 3:2 counters; the carry vector is kept one bit position low.
  always_comb begin
    s_c = src[0 +: DATA_WIDTH];
    c_c = '0;
    x   = '0;
    y   = '0;
    z   = '0;
    for (int r = 1; r < 13; r++) begin
      x   = s_c;
      y   = c_c << 1;
      z   = src[r*DATA_WIDTH +: DATA_WIDTH];
      s_c = x ^ y ^ z;
      c_c = (x & y) | (x & z) | (y & z);
    end
    x   = s_c;
    y   = c_c << 1;
    z   = DATA_WIDTH'(cin);
    s_c = x ^ y ^ z;
    c_c = (x & y) | (x & z) | (y & z);
  end

  always_ff @(posedge clock) begin
    sout <= s_c;
    cout <= c_c;
  end

endmodule

// File: rtl/mul_int_iter_ctrl.sv
// Iterative multiply sequencer: drives the 13-row compressor pass by pass,
// folds the carry-save pair back in, and resolves it into the final product.
module mul_int_iter_ctrl
  import mul_int_pkg::*;
#(
  parameter int OP_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TREE_LAT   = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [OP_WIDTH-1:0]            in_a,
  input  logic [OP_WIDTH-1:0]            in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_product,
  output logic                           busy,
  output logic [TREE_ROWS*DATA_WIDTH-1:0] tree_src,
  output logic [9:0]                     tree_cin,
  input  logic [DATA_WIDTH-1:0]          tree_sout,
  input  logic [DATA_WIDTH-1:0]          tree_cout
);

  localparam int NUM_PASSES = num_passes(OP_WIDTH);
  localparam int PASS_W     = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int WAIT_W     = (TREE_LAT > 1) ? $clog2(TREE_LAT) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TREE_LAT - 1);

  state_e                state_q, state_d;
  logic [OP_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [PASS_W-1:0]     pass_cnt_q, pass_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] sum_acc_q, sum_acc_d;
  logic [DATA_WIDTH-1:0] carry_acc_q, carry_acc_d;
  logic [DATA_WIDTH-1:0] product_q, product_d;

  logic [PP_ROWS_PER_PASS-1:0][DATA_WIDTH-1:0] pp_rows;
  logic [TREE_ROWS*DATA_WIDTH-1:0]             pass_rows;

  mul_int_pp_rowgen #(
    .OP_WIDTH  (OP_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .PASS_W    (PASS_W)
  ) u_rowgen (
    .a       (a_q),
    .b       (b_q),
    .pass_cnt(pass_cnt_q),
    .rows    (pp_rows)
  );

  // Packed row array lays row r at bits [r*DATA_WIDTH +: DATA_WIDTH].
  assign pass_rows = {carry_acc_q << 1, sum_acc_q, pp_rows};
  assign tree_src  = (state_q == ISSUE || state_q == WAIT) ? pass_rows : '0;
  assign tree_cin  = '0;

  assign in_ready    = (state_q == IDLE) && !reset;
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_product = product_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    pass_cnt_d  = pass_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    sum_acc_d   = sum_acc_q;
    carry_acc_d = carry_acc_q;
    product_d   = product_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d         = in_a;
          b_d         = in_b;
          sum_acc_d   = '0;
          carry_acc_d = '0;
          pass_cnt_d  = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          sum_acc_d   = tree_sout;
          carry_acc_d = tree_cout;
          if (pass_cnt_q == LAST_PASS) begin
            state_d = FINAL;
          end else begin
            pass_cnt_d = pass_cnt_q + 1'b1;
            state_d    = ISSUE;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      FINAL: begin
        product_d = sum_acc_q + (carry_acc_q << 1);
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignment so every flop samples
  // pre-edge values; the synchronous reset clears datapath registers too.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      pass_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      sum_acc_q   <= '0;
      carry_acc_q <= '0;
      product_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pass_cnt_q  <= pass_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      sum_acc_q   <= sum_acc_d;
      carry_acc_q <= carry_acc_d;
      product_q   <= product_d;
    end
  end

endmodule

// File: tb/tb_mul_int_iter_ctrl.sv
// Self-checking bench for mul_int_iter_ctrl driving a real 13-row compressor.
// Expected products are queued at acceptance and compared at handoff.
module tb_mul_int_iter_ctrl;

  localparam int OPW     = 32;
  localparam int DW      = 64;
  localparam int LAT_EXP = 8;
  localparam int N_RAND  = 2000;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [OPW-1:0]  in_a = '0;
  logic [OPW-1:0]  in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_product;
  logic            busy;
  logic [13*DW-1:0] tree_src;
  logic [9:0]      tree_cin;
  logic [DW-1:0]   tree_sout;
  logic [DW-1:0]   tree_cout;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clock = ~clock;

  mul_int_iter_ctrl #(
    .OP_WIDTH  (OPW),
    .DATA_WIDTH(DW),
    .TREE_LAT  (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product),
    .busy       (busy),
    .tree_src   (tree_src),
    .tree_cin   (tree_cin),
    .tree_sout  (tree_sout),
    .tree_cout  (tree_cout)
  );

  wtree_13bits_full #(.DATA_WIDTH(DW)) u_tree (
    .clock(clock),
    .src  (tree_src),
    .cin  (tree_cin),
    .sout (tree_sout),
    .cout (tree_cout)
  );

  // Offer an operand pair; called just after a rising edge. Returns just
  // after the accepting edge with the golden product queued.
  task automatic send(input logic [OPW-1:0] a, input logic [OPW-1:0] b, output bit ok);
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      exp_q.push_back(DW'(a) * DW'(b));
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Count falling edges from the accept edge until out_valid is seen.
  task automatic wait_valid(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clock);
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic logic [OPW-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return OPW'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (tree_src !== '0) begin failures++; $display("FAIL reset_tree_src: got nonzero expected 0"); end
    checks++;
    if (out_product !== '0) begin failures++; $display("FAIL reset_product: got %h expected 0", out_product); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (tree_cin !== '0) begin failures++; $display("FAIL tree_cin: got %h expected 0", tree_cin); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    send(32'd3, 32'd5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_accept: got timeout expected accept"); end
    wait_valid(20, n);
    checks++;
    if (n != LAT_EXP) begin failures++; $display("FAIL basic_latency: got %0d expected %0d", n, LAT_EXP); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if (out_product !== exp) begin failures++; $display("FAIL basic_product: got %h expected %h", out_product, exp); end
    checks++;
    if (out_product !== 64'd15) begin failures++; $display("FAIL basic_product_const: got %h expected 15", out_product); end
    @(negedge clock);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_pulse: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after: got %b expected 1", in_ready); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_corners();
    logic [OPW-1:0] a_list [3] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0000};
    logic [OPW-1:0] b_list [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [DW-1:0]  c_list [3] = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h0};
    bit ok;
    int n;
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(a_list[k], b_list[k], ok);
      wait_valid(20, n);
      checks++;
      if (n != LAT_EXP) begin failures++; $display("FAIL corner%0d_latency: got %0d expected %0d", k, n, LAT_EXP); end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++;
      if (out_product !== exp) begin failures++; $display("FAIL corner%0d_product: got %h expected %h", k, out_product, exp); end
      checks++;
      if (out_product !== c_list[k]) begin failures++; $display("FAIL corner%0d_const: got %h expected %h", k, out_product, c_list[k]); end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    logic [DW-1:0] first;
    logic [DW-1:0] exp;
    out_ready = 1'b0;
    send(32'h0000_0F0F, 32'h0000_0003, ok);
    wait_valid(20, n);
    checks++;
    if (n != LAT_EXP) begin failures++; $display("FAIL b2b_latency: got %0d expected %0d", n, LAT_EXP); end
    first = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    in_a     = 32'h1234;
    in_b     = 32'h5678;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_product !== first) begin
        failures++;
        $display("FAIL b2b_hold%0d: got valid=%b product=%h expected valid=1 product=%h", k, out_valid, out_product, first);
      end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready%0d: got %b expected 0", k, in_ready); end
      @(negedge clock);
    end
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_product !== first) begin
      failures++;
      $display("FAIL b2b_handoff: got valid=%b product=%h expected valid=1 product=%h", out_valid, out_product, first);
    end
    @(posedge clock);
    #1;
    send(32'h1234, 32'h5678, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_second_accept: got timeout expected accept"); end
    wait_valid(20, n);
    checks++;
    if (n != LAT_EXP) begin failures++; $display("FAIL b2b_second_latency: got %0d expected %0d", n, LAT_EXP); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if (out_product !== exp || out_product !== 64'h0626_0060) begin
      failures++;
      $display("FAIL b2b_second_product: got %h expected %h", out_product, 64'h0626_0060);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int n;
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    send(32'hDEAD_BEEF, 32'hCAFE_BABE, ok);
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (seen) begin failures++; $display("FAIL midreset_no_valid: got out_valid=1 expected none"); end
    @(posedge clock);
    #1;
    send(32'd7, 32'd9, ok);
    wait_valid(20, n);
    checks++;
    if (n != LAT_EXP) begin failures++; $display("FAIL midreset_latency: got %0d expected %0d", n, LAT_EXP); end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if (out_product !== exp || out_product !== 64'd63) begin
      failures++;
      $display("FAIL midreset_product: got %h expected 63", out_product);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    int sent = 0;
    int recv = 0;
    bit prev_stall = 1'b0;
    bit accept;
    logic [DW-1:0] held = '0;
    logic [DW-1:0] exp;
    for (int cyc = 0; cyc < 60000 && recv < N_RAND; cyc++) begin
      if (!in_valid && sent < N_RAND && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_a     = rand_op();
        in_b     = rand_op();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      accept = in_valid && in_ready;
      if (accept) begin
        exp_q.push_back(DW'(in_a) * DW'(in_b));
        sent++;
      end
      checks++;
      if (in_ready && busy) begin failures++; $display("FAIL rand_ready_busy: got both high expected exclusive"); end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_product !== held) begin
          failures++;
          $display("FAIL rand_stall_hold: got valid=%b product=%h expected valid=1 product=%h", out_valid, out_product, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra_result: got product=%h expected none", out_product);
        end else begin
          exp = exp_q.pop_front();
          if (out_product !== exp) begin
            failures++;
            $display("FAIL rand_product: got %h expected %h", out_product, exp);
          end
        end
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      held       = out_product;
      @(posedge clock);
      #1;
      if (accept) in_valid = 1'b0;
    end
    checks++;
    if (recv != N_RAND) begin failures++; $display("FAIL rand_count: got %0d expected %0d", recv, N_RAND); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL rand_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
